// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bridge and its register bank.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  localparam int         CMD_RW_BIT      = 7;
  localparam int         ADDR_W          = 7;
  localparam logic [7:0] ID_BYTE_DEFAULT = 8'hA5;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int num_regs);
    return int'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Byte handshake between the SPI peripheral (master side) and the register bridge (slave side).
interface spi_reg_bridge_if;

  logic       i_rxDataValid;
  logic [7:0] i_rxData;
  logic       o_txDataValid;
  logic [7:0] o_txData;

  modport master (
    output i_rxDataValid,
    output i_rxData,
    input  o_txDataValid,
    input  o_txData
  );

  modport slave (
    input  i_rxDataValid,
    input  i_rxData,
    output o_txDataValid,
    output o_txData
  );

endinterface

// File: rtl/spi_reg_bank.sv
// Local register bank: range-checked write port, registered write strobe/address,
// and a combinational read mux that returns 8'h00 for unimplemented addresses.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wrEn,
  input  logic [ADDR_W-1:0]     i_wrAddr,
  input  logic [7:0]            i_wrData,
  input  logic [ADDR_W-1:0]     i_rdAddr,
  output logic [7:0]            o_rdData,
  output logic [8*NUM_REGS-1:0] o_regs,
  output logic                  o_wrStrobe,
  output logic [ADDR_W-1:0]     o_wrAddr
);

  logic [8*NUM_REGS-1:0] r_regs;
  logic                  r_wrStrobe;
  logic [ADDR_W-1:0]     r_wrAddr;
  logic                  w_wr_ok;

  assign w_wr_ok = i_wrEn && addr_in_range(i_wrAddr, NUM_REGS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs     <= '0;
      r_wrStrobe <= 1'b0;
      r_wrAddr   <= '0;
    end else begin
      r_wrStrobe <= w_wr_ok;
      if (w_wr_ok) begin
        r_wrAddr <= i_wrAddr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (i_wrAddr == ADDR_W'(i)) r_regs[8*i +: 8] <= i_wrData;
        end
      end
    end
  end

  // No entry matches an out-of-range address, so the default zero is returned.
  always_comb begin
    o_rdData = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_rdAddr == ADDR_W'(i)) o_rdData = r_regs[8*i +: 8];
    end
  end

  assign o_regs     = r_regs;
  assign o_wrStrobe = r_wrStrobe;
  assign o_wrAddr   = r_wrAddr;

endmodule

// File: rtl/spi_reg_bridge.sv
// Command-decoding register bridge behind a Mode 0 SPI peripheral.
// Build option SPI_REG_AUTOINC_EN: address auto-increments after each data byte (burst).
//
// state  | meaning
// IDLE   | frame closed, ID byte loaded for transmit
// CMD    | waiting for the command byte {rw, addr}
// WRITE  | each received byte is written to reg[addr]
// READ   | each received dummy byte loads the next read byte
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] ID_BYTE  = ID_BYTE_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_SPI_CS_n,
  spi_reg_bridge_if.slave       spi,
  output logic [8*NUM_REGS-1:0] o_regs,
  output logic                  o_wrStrobe,
  output logic [ADDR_W-1:0]     o_wrAddr,
  output logic                  o_addrErr
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_CMD   = 2'(ST_CMD);
  localparam logic [1:0] S_WRITE = 2'(ST_WRITE);
  localparam logic [1:0] S_READ  = 2'(ST_READ);

`ifdef SPI_REG_AUTOINC_EN
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(0);
`endif

  logic              r_cs_meta1, r_cs_meta2, r_cs_align;
  logic [1:0]        r_flush;
  logic              r_armed;
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_txData;
  logic              r_txDataValid;
  logic              r_load_id;
  logic              r_addrErr;

  logic              w_cs_fall, w_cs_rise, w_enter_idle;
  logic              w_rx, w_cmd_rd;
  logic [ADDR_W-1:0] w_cmd_addr, w_addr_next, w_rd_addr;
  logic              w_wr_en, w_rd_load, w_wr_err, w_rd_err;
  logic [7:0]        w_rd_data;

  // Edges are taken between meta2 and the alignment flop so the FSM reacts on
  // the same edge the aligned CS changes. A fall only counts once CS has been
  // seen high after reset, so a reset inside a frame waits for the next frame.
  assign w_cs_fall    = r_armed & r_cs_align & ~r_cs_meta2;
  assign w_cs_rise    = ~r_cs_align & r_cs_meta2;
  assign w_enter_idle = w_cs_rise && (r_state != S_IDLE);

  assign w_rx        = spi.i_rxDataValid;
  assign w_cmd_rd    = spi.i_rxData[CMD_RW_BIT];
  assign w_cmd_addr  = spi.i_rxData[ADDR_W-1:0];
  assign w_addr_next = r_addr + ADDR_STEP;

  always_comb begin
    w_wr_en   = 1'b0;
    w_rd_load = 1'b0;
    w_rd_addr = r_addr;
    case (r_state)
      S_CMD: begin
        if (w_rx && w_cmd_rd) begin
          w_rd_load = 1'b1;
          w_rd_addr = w_cmd_addr;
        end
      end
      S_WRITE: w_wr_en = w_rx;
      S_READ: begin
        if (w_rx) begin
          w_rd_load = 1'b1;
          w_rd_addr = w_addr_next;
        end
      end
      default: ;
    endcase
  end

  assign w_wr_err = w_wr_en & ~addr_in_range(r_addr, NUM_REGS);
  assign w_rd_err = w_rd_load & ~addr_in_range(w_rd_addr, NUM_REGS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs_meta1 <= 1'b1;
      r_cs_meta2 <= 1'b1;
      r_cs_align <= 1'b1;
      r_flush    <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_cs_meta1 <= i_SPI_CS_n;
      r_cs_meta2 <= r_cs_meta1;
      r_cs_align <= r_cs_meta2;
      r_flush    <= {r_flush[0], 1'b1};
      r_armed    <= r_armed | (r_flush[1] & r_cs_meta2);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_cs_fall) r_state <= S_CMD;
        S_CMD: begin
          if (w_rx) begin
            r_addr  <= w_cmd_addr;
            r_state <= w_cmd_rd ? S_READ : S_WRITE;
          end
        end
        S_WRITE, S_READ: if (w_rx) r_addr <= w_addr_next;
        default: r_state <= S_IDLE;
      endcase
      // Any byte in this cycle has already been acted on above; the close wins the state.
      if (w_enter_idle) r_state <= S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_txData      <= ID_BYTE;
      r_txDataValid <= 1'b0;
      r_load_id     <= 1'b1;
      r_addrErr     <= 1'b0;
    end else begin
      r_addrErr <= r_addrErr | w_wr_err | w_rd_err;
      if (r_load_id || w_enter_idle) begin
        r_txData      <= ID_BYTE;
        r_txDataValid <= 1'b1;
        r_load_id     <= 1'b0;
      end else if (w_rd_load) begin
        r_txData      <= w_rd_data;
        r_txDataValid <= 1'b1;
      end else begin
        r_txDataValid <= 1'b0;
      end
    end
  end

  spi_reg_bank #(
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wrEn     (w_wr_en),
    .i_wrAddr   (r_addr),
    .i_wrData   (spi.i_rxData),
    .i_rdAddr   (w_rd_addr),
    .o_rdData   (w_rd_data),
    .o_regs     (o_regs),
    .o_wrStrobe (o_wrStrobe),
    .o_wrAddr   (o_wrAddr)
  );

  assign spi.o_txData      = r_txData;
  assign spi.o_txDataValid = r_txDataValid;
  assign o_addrErr         = r_addrErr;

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Byte-level register-access bridge that sits directly downstream of the Mode 0 SPI peripheral in the main clock domain. It consumes received-byte pulses and returns read data through the peripheral's transmit-byte load interface. It frames transactions using a synchronized copy of the SPI chip select. It decodes a command byte, then performs single or burst writes and reads on a small local register bank exposed to the rest of the design.

## Interface
Parameters:
- NUM_REGS, 16: implemented registers at addresses 0..NUM_REGS-1; legal range 1..128.
- ID_BYTE, 8'hA5: byte loaded for transmit while idle; it is the first byte shifted out in every frame.

Ports:
- i_clk  in  1  main clock; the block's only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_SPI_CS_n  in  1  raw chip select from pin; asynchronous, synchronized internally.
- i_rxDataValid  in  1  one-cycle pulse: received byte valid.
- i_rxData  in  8  received byte.
- o_txDataValid  out  1  one-cycle pulse: load o_txData into the peripheral.
- o_txData  out  8  next byte to shift out.
- o_regs  out  8*NUM_REGS  flattened register bank; register n is at bits [8n+7:8n].
- o_wrStrobe  out  1  one-cycle pulse when a register is written.
- o_wrAddr  out  7  address of the last write.
- o_addrErr  out  1  sticky flag set when any access targets an address ≥ NUM_REGS.

## Operation
- Command byte: first byte of a frame, {rw, addr[6:0]}. rw=0 means write, rw=1 means read.
- States: IDLE, CMD, WRITE, READ.
  - IDLE: synced CS high. On synced CS falling edge, go to CMD.
  - CMD: on i_rxDataValid, latch addr. Go to WRITE if rw=0, otherwise READ.
  - WRITE: each i_rxDataValid writes i_rxData to reg[addr]. Then addr advances (see Configuration).
  - READ: on entry, load reg[addr]. Each i_rxDataValid (a dummy byte, ignored) advances addr and loads the next reg[addr].
- Synced CS rising edge returns any state to IDLE and aborts the transaction. Completed register writes are kept.
- Simultaneous synced CS rise and i_rxDataValid in the same cycle: the byte is processed first, then the FSM enters IDLE.
- Out-of-range address:
  - Write is dropped and o_wrStrobe is not pulsed.
  - Read returns 8'h00.
  - o_addrErr is set in either case.
- Address arithmetic: 7-bit, wraps 7'h7F to 7'h00.

## Timing
- CS synchronizer: 2 metastability flops plus 1 alignment flop, 3 cycles total. This matches the peripheral's receive-valid path, so a frame's final byte pulse never arrives after the frame has closed.
- Write: reg[addr], o_wrStrobe and o_wrAddr update 1 cycle after i_rxDataValid.
- Read: o_txData and o_txDataValid are updated 1 cycle after the i_rxDataValid that triggered the load.
  - The load lands within 5 main clocks of the byte's final SPI edge.
  - The SPI clock half-period must exceed 5 main-clock periods.
- IDLE entry (including the first cycle after reset): o_txData = ID_BYTE, with a single o_txDataValid pulse.
- Reset values:
  - o_regs all 0.
  - o_txData = ID_BYTE.
  - o_txDataValid, o_wrStrobe and o_addrErr = 0.
  - o_wrAddr = 0.
  - FSM = IDLE; CS synchronizer flops = 1.
- Reset mid-frame: the FSM returns to IDLE and all state clears. It stays in IDLE until the synced CS goes high and then low again.

## Configuration
- SPI_REG_AUTOINC_EN defined: addr increments by 1 after each data byte in WRITE and READ (burst access).
- SPI_REG_AUTOINC_EN undefined: addr stays fixed for the whole frame. Repeated writes overwrite one register; repeated reads return the same register.

## Structure
- Package spi_reg_pkg holds:
  - the state enum typedef (IDLE/CMD/WRITE/READ);
  - CMD_RW_BIT = 7;
  - ADDR_W = 7;
  - the default ID_BYTE constant.
- Sub-module spi_reg_bank contains:
  - NUM_REGS × 8 storage with synchronous reset;
  - a write port with range check;
  - a combinational read mux that returns 8'h00 when out of range.
- The FSM, CS synchronizer and address counter stay in spi_reg_bridge.

## Test plan
- Reset, then idle with CS high: o_txData = 8'hA5 with one o_txDataValid pulse; o_regs = 0.
- Frame with bytes 8'h03, 8'h5A: reg[3] = 8'h5A and one o_wrStrobe with o_wrAddr = 3. Close CS, then read with frame 8'h83, dummy: o_txData = 8'h5A one cycle after the command byte's valid pulse.
- With SPI_REG_AUTOINC_EN: frame 8'h0E, 8'h11, 8'h22 sets reg[14] = 8'h11 and reg[15] = 8'h22. Without the macro: reg[14] = 8'h22 and reg[15] is unchanged.
- Write 8'h20 (address 32 ≥ 16), data 8'hFF: no o_regs change, no strobe, o_addrErr = 1. Read of address 8'hA0 returns 8'h00.
- CS rising in the same cycle as a data byte's valid pulse (after sync alignment): the write commits, then the FSM is in IDLE.
- Assert i_rst mid-burst: all o_regs = 0 and o_txData = 8'hA5. The next frame decodes its first byte as a command.
